swervolf_sevenseg_mux: RTL and testbench



---
 rtl/swervolf_sevenseg_mux.sv | 154 +++++++++++++++
 tb/tb_swervolf_sevenseg_mux.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/swervolf_sevenseg_mux.sv
// swervolf_sevenseg_mux
//
// Time-multiplexed seven-segment display controller. The display is scanned one
// digit per slot of PRESCALE core cycles. Each slot starts with BLANK_CYCLES
// cycles where every anode is off, which prevents ghosting. A newly loaded value
// first goes into a shadow register. It reaches the display register only at a
// frame boundary, so a single frame never shows a mix of two values.
//
// Ports:
//   clk_core    core clock
//   rstn        asynchronous active-low reset
//   i_value     hex nibbles, digit k = i_value[4k+3:4k], digit 0 rightmost
//   i_load      strobe, samples i_value into the shadow register
//   i_digit_en  per-digit enable, 0 forces the digit blank (anode still driven)
//   i_dp        per-digit decimal point, sampled live
//   i_lz_blank  suppress leading zeros (digit 0 is never suppressed)
//   o_an        anode enables, one-hot active or all inactive
//   o_seg       segments, bit0 = a .. bit6 = g
//   o_dp        decimal point
//   o_frame     one-cycle pulse, high in the cycle the display register updates
module swervolf_sevenseg_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                      clk_core,
  input  logic                      rstn,
  input  logic [4*NUM_DIGITS-1:0]   i_value,
  input  logic                      i_load,
  input  logic [NUM_DIGITS-1:0]     i_digit_en,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic                      i_lz_blank,
  output logic [NUM_DIGITS-1:0]     o_an,
  output logic [6:0]                o_seg,
  output logic                      o_dp,
  output logic                      o_frame
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCNT_W = $clog2(PRESCALE);
  localparam logic POL  = (ACTIVE_LOW != 0);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]       pcnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] shadow_reg;
  logic [4*NUM_DIGITS-1:0] display_reg;

  logic tick;
  logic frame_next;
  logic blank_win;
  logic digit_blank;

  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  logic [3:0]            disp_nib [NUM_DIGITS];
  // upper_zero[k] is set when the display nibbles from NUM_DIGITS-1 down to k are all zero.
  logic [NUM_DIGITS-1:0] upper_zero;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  assign tick       = (pcnt_reg == PCNT_LAST);
  assign frame_next = tick && (idx_reg == IDX_LAST);
  assign blank_win  = (pcnt_reg < BLANK_END);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign disp_nib[gi]   = display_reg[4*gi +: 4];
    assign upper_zero[gi] = (display_reg[4*NUM_DIGITS-1:4*gi] == '0);
  end

  assign digit_blank = !i_digit_en[idx_reg] ||
                       (i_lz_blank && (idx_reg != '0) && upper_zero[idx_reg]);

  // Scan state: prescale counter and digit index.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      pcnt_reg <= '0;
      idx_reg  <= '0;
    end else if (tick) begin
      pcnt_reg <= '0;
      idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      pcnt_reg <= pcnt_reg + 1'b1;
    end
  end

  // A load on the boundary cycle lands in the shadow register. The display register
  // takes the old shadow contents, so the new value waits one more frame.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      shadow_reg  <= '0;
      display_reg <= '0;
    end else begin
      if (i_load)
        shadow_reg <= i_value;
      if (frame_next)
        display_reg <= shadow_reg;
    end
  end

  always_comb begin
    an_next  = '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (!blank_win) begin
      an_next[idx_reg] = 1'b1;
      if (!digit_blank) begin
        seg_next = decode(disp_nib[idx_reg]);
        dp_next  = i_dp[idx_reg];
      end
    end
  end

  // Single output stage. Polarity is applied here so that all pins switch together.
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      o_an    <= {NUM_DIGITS{POL}};
      o_seg   <= {7{POL}};
      o_dp    <= POL;
      o_frame <= 1'b0;
    end else begin
      o_an    <= an_next ^ {NUM_DIGITS{POL}};
      o_seg   <= seg_next ^ {7{POL}};
      o_dp    <= dp_next ^ POL;
      o_frame <= frame_next;
    end
  end

endmodule

// File: tb/tb_swervolf_sevenseg_mux.sv
// Directed testbench for swervolf_sevenseg_mux. The configuration is
// NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
// cyc counts falling edges after reset release. The outputs seen at cyc = c were
// registered at rising edge c, from the scan state present before that edge:
// slot = ((c-1)/4)%4, phase = (c-1)%4, and phase 0 is the blank window.
module tb_swervolf_sevenseg_mux;

  logic        clk_core;
  logic        rstn;
  logic [15:0] i_value;
  logic        i_load;
  logic [3:0]  i_digit_en;
  logic [3:0]  i_dp;
  logic        i_lz_blank;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  int vectors;
  int miscompares;
  int cyc;

  swervolf_sevenseg_mux #(
    .NUM_DIGITS  (4),
    .PRESCALE    (4),
    .BLANK_CYCLES(1),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_core  (clk_core),
    .rstn      (rstn),
    .i_value   (i_value),
    .i_load    (i_load),
    .i_digit_en(i_digit_en),
    .i_dp      (i_dp),
    .i_lz_blank(i_lz_blank),
    .o_an      (o_an),
    .o_seg     (o_seg),
    .o_dp      (o_dp),
    .o_frame   (o_frame)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("cyc %0d %s: observed %h expected %h", cyc, tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg,
                         input logic dp);
    chk({tag, ".an"},  {28'd0, o_an},  {28'd0, an});
    chk({tag, ".seg"}, {25'd0, o_seg}, {25'd0, seg});
    chk({tag, ".dp"},  {31'd0, o_dp},  {31'd0, dp});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(negedge clk_core);
      cyc++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rstn        = 1'b0;
    i_value     = 16'h0000;
    i_load      = 1'b0;
    i_digit_en  = 4'hF;
    i_dp        = 4'h0;
    i_lz_blank  = 1'b0;

    // 1. Reset state, then the first slots after release.
    repeat (3) @(negedge clk_core);
    chk_out("rst", 4'hF, 7'h7F, 1'b1);
    chk("rst.frame", {31'd0, o_frame}, 32'd0);
    rstn = 1'b1;
    cyc  = 0;
    wait_to(1);  chk_out("s0_blank", 4'hF, 7'h7F, 1'b1);
    wait_to(2);  chk_out("s0_p1", 4'hE, 7'h40, 1'b1);
    wait_to(4);  chk("s0_p3.an", {28'd0, o_an}, 32'hE);
    wait_to(5);  chk("s1_blank.an", {28'd0, o_an}, 32'hF);
    wait_to(6);  chk("s1_p1.an", {28'd0, o_an}, 32'hD);

    // 2. Scan and decode of 12AF. The value is loaded mid-frame and becomes visible
    //    in frame 2.
    i_value = 16'h12AF; i_load = 1'b1;
    wait_to(7);  i_load = 1'b0;
    wait_to(15); chk("frame15", {31'd0, o_frame}, 32'd0);
    wait_to(16); chk("frame16", {31'd0, o_frame}, 32'd1);
    wait_to(17); chk("frame17", {31'd0, o_frame}, 32'd0);
    wait_to(18); chk_out("d0_F", 4'hE, 7'h0E, 1'b1);
    wait_to(22); chk_out("d1_A", 4'hD, 7'h08, 1'b1);
    wait_to(26); chk_out("d2_2", 4'hB, 7'h24, 1'b1);
    wait_to(30); chk_out("d3_1", 4'h7, 7'h79, 1'b1);
    wait_to(32); chk("frame32", {31'd0, o_frame}, 32'd1);

    // 3. Tear-free update. 1111 and then 2222 are loaded mid-frame. 3333 is loaded
    //    on the boundary cycle, which is sampled at edge 48.
    wait_to(33); i_value = 16'h1111; i_load = 1'b1;
    wait_to(34); i_load = 1'b0;
    wait_to(40); i_value = 16'h2222; i_load = 1'b1;
    wait_to(41); i_load = 1'b0;
    wait_to(46); chk_out("f3_d3_hold", 4'h7, 7'h79, 1'b1);
    wait_to(47); i_value = 16'h3333; i_load = 1'b1;
    wait_to(48); i_load = 1'b0;
    chk("frame48", {31'd0, o_frame}, 32'd1);
    wait_to(50); chk_out("f4_d0_2", 4'hE, 7'h24, 1'b1);
    wait_to(54); chk_out("f4_d1_2", 4'hD, 7'h24, 1'b1);
    wait_to(58); chk_out("f4_d2_2", 4'hB, 7'h24, 1'b1);
    wait_to(62); chk_out("f4_d3_2", 4'h7, 7'h24, 1'b1);
    wait_to(66); chk_out("f5_d0_3", 4'hE, 7'h30, 1'b1);
    wait_to(78); chk_out("f5_d3_3", 4'h7, 7'h30, 1'b1);

    // 4. Per-digit blanking and decimal points.
    wait_to(80); i_digit_en = 4'b1010; i_dp = 4'b0011;
    wait_to(81); chk_out("bl_window", 4'hF, 7'h7F, 1'b1);
    wait_to(82); chk_out("bl_d0_off", 4'hE, 7'h7F, 1'b1);
    wait_to(86); chk_out("bl_d1_dp", 4'hD, 7'h30, 1'b0);
    wait_to(90); chk_out("bl_d2_off", 4'hB, 7'h7F, 1'b1);
    wait_to(94); chk_out("bl_d3_nodp", 4'h7, 7'h30, 1'b1);

    // 5. Leading-zero suppression with 0040, and then with 0000.
    i_digit_en = 4'hF; i_dp = 4'h0; i_lz_blank = 1'b1;
    i_value = 16'h0040; i_load = 1'b1;
    wait_to(95);  i_load = 1'b0;
    wait_to(98);  chk_out("lz_d0_0", 4'hE, 7'h40, 1'b1);
    wait_to(100); i_value = 16'h0000; i_load = 1'b1;
    wait_to(101); i_load = 1'b0;
    wait_to(102); chk_out("lz_d1_4", 4'hD, 7'h19, 1'b1);
    wait_to(106); chk_out("lz_d2_blank", 4'hB, 7'h7F, 1'b1);
    wait_to(110); chk_out("lz_d3_blank", 4'h7, 7'h7F, 1'b1);
    wait_to(114); chk_out("lz0_d0_0", 4'hE, 7'h40, 1'b1);
    i_value = 16'h7777; i_load = 1'b1;
    wait_to(115); i_load = 1'b0;
    wait_to(118); chk_out("lz0_d1_blank", 4'hD, 7'h7F, 1'b1);
    wait_to(126); chk_out("lz0_d3_blank", 4'h7, 7'h7F, 1'b1);

    // 6. Reset asserted mid-frame, during slot 2 while 7777 is shown.
    wait_to(138); chk_out("pre_rst_d2_7", 4'hB, 7'h78, 1'b1);
    #2 rstn = 1'b0;
    #1 chk_out("async_rst", 4'hF, 7'h7F, 1'b1);
    chk("async_rst.frame", {31'd0, o_frame}, 32'd0);
    repeat (2) @(negedge clk_core);
    rstn = 1'b1;
    cyc  = 0;
    wait_to(1);  chk("rr_s0_blank.an", {28'd0, o_an}, 32'hF);
    wait_to(2);  chk_out("rr_d0_disp0", 4'hE, 7'h40, 1'b1);
    wait_to(6);  chk_out("rr_d1_lz", 4'hD, 7'h7F, 1'b1);
    wait_to(16); chk("rr_frame16", {31'd0, o_frame}, 32'd1);
    wait_to(18); chk_out("rr_d0_shadow0", 4'hE, 7'h40, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
